// File: rtl/nios2pio_qsys_debug_ocimem_seq.sv
`default_nettype none
// ============================================================================
// Module      : nios2pio_qsys_debug_ocimem_seq
// Description : Turns debug-slave command pulses into single-word Avalon-MM
//               accesses on the debug memory, with auto-increment and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2pio_qsys_debug_ocimem_seq #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              ocimem_busy,
  output logic              ocimem_err
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_RD      = 2'd1;
  localparam logic [1:0]  c_WR      = 2'd2;
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] mona_q,   mona_d;
  logic [31:0]       mond_q,   mond_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [15:0]       cnt_q,    cnt_d;
  logic              err_q,    err_d;

  logic w_take_any;
  logic w_unused;

  assign w_take_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_unused   = ^{jdo[37:36], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      mona_q  <= '0;
      mond_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mona_q  <= mona_d;
      mond_q  <= mond_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mona_d  = mona_q;
    mond_d  = mond_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      c_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          mond_d  = jdo[34:3];
          cnt_d   = '0;
          state_d = c_WR;
          if (take_action_ocimem_a | take_no_action_ocimem_a) err_d = 1'b1;
        end else if (take_action_ocimem_a) begin
          mona_d = jdo[25+ADDR_W:26];
          if (jdo[35]) err_d = 1'b0;
          if (jdo[34]) begin
            cnt_d   = '0;
            state_d = c_RD;
          end
          // A dropped companion pulse must win over the clear request
          if (take_no_action_ocimem_a) err_d = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          cnt_d   = '0;
          state_d = c_RD;
        end
      end
      c_RD, c_WR: begin
        if (w_take_any) err_d = 1'b1;
        if (!avm_waitrequest) begin
          if (state_q == c_RD) mond_d = avm_readdata;
          mona_d  = mona_q + ADDR_W'(1);
          state_d = c_IDLE;
        end else if (cnt_q == c_TO_LAST) begin
          if (state_q == c_RD) mond_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = c_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Requests are gated by reset so they drop in the cycle reset is sampled
  always_comb begin
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    ocimem_busy = 1'b0;
    case (state_q)
      c_RD: begin
        avm_read    = ~reset;
        ocimem_busy = 1'b1;
      end
      c_WR: begin
        avm_write   = ~reset;
        ocimem_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign avm_address   = mona_q;
  assign avm_writedata = wdata_q;
  assign MonDReg       = mond_q;
  assign MonAReg       = mona_q;
  assign ocimem_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2pio_qsys_debug_ocimem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2pio_qsys_debug_ocimem_seq
// Description : Self-checking bench: directed and random debug-memory accesses
//               against a transaction-level model and a slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2pio_qsys_debug_ocimem_seq;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        ocimem_busy, ocimem_err;

  nios2pio_qsys_debug_ocimem_seq #(
    .ADDR_W  (8),
    .TIMEOUT (TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_a),
    .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b   (take_b),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_waitrequest        (avm_waitrequest),
    .avm_readdata           (avm_readdata),
    .MonDReg                (MonDReg),
    .MonAReg                (MonAReg),
    .ocimem_busy            (ocimem_busy),
    .ocimem_err             (ocimem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model and the bench-owned slave memory
  logic [7:0]  m_a;
  logic [31:0] m_d;
  logic        m_err;
  logic [31:0] ref_mem [256];
  logic [31:0] mem     [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] rnd38();
    return {6'($urandom), 32'($urandom)};
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the pulse edge
  task automatic pulse(input bit a, input bit na, input bit b, input logic [37:0] j);
    take_a = a; take_na = na; take_b = b; jdo = j;
    @(negedge clk);
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0; jdo = rnd38();
  endtask

  // Acts as the Avalon slave for one access; optional overlapping write pulse
  task automatic serve(input int nwait, input bit want_wr, input int inj,
                       output int busy_n, output bit ok, output logic [7:0] a0);
    int stalls = 0;
    ok = 1'b1;
    busy_n = 0;
    a0 = avm_address;
    while (ocimem_busy === 1'b1 && busy_n < 300) begin
      if (avm_address !== a0) ok = 1'b0;
      if (want_wr ? (avm_write !== 1'b1 || avm_read !== 1'b0)
                  : (avm_read !== 1'b1 || avm_write !== 1'b0)) ok = 1'b0;
      avm_waitrequest = (stalls < nwait);
      if (avm_waitrequest) stalls++;
      avm_readdata = mem[avm_address];
      if (!avm_waitrequest && avm_write) mem[avm_address] = avm_writedata;
      if (busy_n == inj) begin
        take_b = 1'b1;
        jdo = rnd38();
      end else begin
        take_b = 1'b0;
      end
      busy_n++;
      @(negedge clk);
    end
    take_b = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  // kind: 0 = no access, 1 = read, 2 = write
  task automatic access(input int kind, input int nwait, input int inj,
                        input logic [31:0] wd, input string tag);
    int          bn;
    bit          ok;
    logic [7:0]  a0;
    logic [7:0]  ea;
    bit          to;
    int          exp_bn;
    ea = m_a;
    serve(nwait, kind == 2, inj, bn, ok, a0);
    to = (kind != 0) && (nwait >= TO);
    if (inj >= 0) m_err = 1'b1;
    if (kind == 1) begin
      if (to) begin m_d = ERR; m_err = 1'b1; end
      else    begin m_d = ref_mem[m_a]; m_a = m_a + 8'd1; end
    end else if (kind == 2) begin
      m_d = wd;
      if (to) m_err = 1'b1;
      else begin ref_mem[m_a] = wd; m_a = m_a + 8'd1; end
    end
    exp_bn = (kind == 0) ? 0 : (to ? TO : nwait + 1);
    if (kind != 0) begin
      chk({tag, ".addr"},   32'(a0), 32'(ea));
      chk({tag, ".stable"}, 32'(ok), 32'd1);
    end
    chk({tag, ".busycyc"}, 32'(bn), 32'(exp_bn));
    chk({tag, ".mond"},    MonDReg, m_d);
    chk({tag, ".mona"},    32'(MonAReg), 32'(m_a));
    chk({tag, ".err"},     32'(ocimem_err), 32'(m_err));
    chk({tag, ".idle"},    32'(ocimem_busy), 32'd0);
  endtask

  task automatic op_load(input logic [7:0] addr, input bit rd, input bit clr,
                         input int nwait, input string tag);
    logic [37:0] j;
    j = rnd38();
    j[33:26] = addr; j[34] = rd; j[35] = clr;
    pulse(1'b1, 1'b0, 1'b0, j);
    m_a = addr;
    if (clr) m_err = 1'b0;
    access(rd ? 1 : 0, nwait, -1, 32'd0, tag);
  endtask

  task automatic op_read(input int nwait, input int inj, input string tag);
    pulse(1'b0, 1'b1, 1'b0, rnd38());
    access(1, nwait, inj, 32'd0, tag);
  endtask

  task automatic op_write(input logic [31:0] d, input int nwait, input string tag);
    logic [37:0] j;
    j = rnd38();
    j[34:3] = d;
    pulse(1'b0, 1'b0, 1'b1, j);
    access(2, nwait, -1, d, tag);
  endtask

  initial begin
    logic [37:0] j;
    logic [31:0] d;
    int          r, nw, diffs;
    bit          seen;

    reset = 1'b1;
    jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    m_a = '0; m_d = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.mond", MonDReg, 32'd0);
    chk("rst.mona", 32'(MonAReg), 32'd0);
    chk("rst.rdwr", 32'({avm_read, avm_write}), 32'd0);
    chk("rst.wdata", avm_writedata, 32'd0);
    chk("rst.busyerr", 32'({ocimem_busy, ocimem_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mem[8'h10] = 32'h12345678; ref_mem[8'h10] = 32'h12345678;
    op_load(8'h10, 1'b1, 1'b0, 0, "ldrd");
    chk("ldrd.val", MonDReg, 32'h12345678);

    op_load(8'h20, 1'b0, 1'b0, 0, "ld20");
    op_write(32'hA, 0, "wrA");
    op_write(32'hB, 0, "wrB");
    op_write(32'hC, 0, "wrC");
    chk("slave20", mem[8'h20], 32'hA);
    chk("slave21", mem[8'h21], 32'hB);
    chk("slave22", mem[8'h22], 32'hC);
    op_load(8'h20, 1'b0, 1'b0, 0, "ld20b");
    op_read(0, -1, "rdA");
    op_read(0, -1, "rdB");
    op_read(0, -1, "rdC");
    chk("rdC.val", MonDReg, 32'hC);

    op_load(8'h40, 1'b0, 1'b0, 0, "ld40");
    op_read(5, -1, "wait5");
    op_read(TO - 1, -1, "wait7");
    op_read(20, -1, "tmo_rd");
    chk("tmo_rd.val", MonDReg, ERR);
    op_load(8'h50, 1'b0, 1'b1, 0, "clr");
    chk("clr.err", 32'(ocimem_err), 32'd0);

    op_load(8'h60, 1'b0, 1'b0, 0, "ld60");
    op_read(5, 2, "ovl");
    op_load(8'h61, 1'b0, 1'b1, 0, "clr2");
    op_write(32'h5A5A0001, 20, "tmo_wr");

    // Simultaneous pulses: a beats no_action, then b beats a
    j = rnd38(); j[33:26] = 8'h70; j[34] = 1'b0;
    pulse(1'b1, 1'b1, 1'b0, j);
    m_a = 8'h70; m_err = 1'b1;
    access(0, 0, -1, 32'd0, "sim_a");
    d = $urandom; j = rnd38(); j[34:3] = d;
    pulse(1'b1, 1'b0, 1'b1, j);
    m_err = 1'b1;
    access(2, 0, -1, d, "sim_b");

    op_load(8'hFF, 1'b1, 1'b1, 0, "wrap");
    chk("wrap.a0", 32'(MonAReg), 32'd0);

    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 9);
      nw = (r < 6) ? (r % 3) : ((r < 8) ? TO - 1 : TO + 2);
      case ($urandom_range(0, 2))
        0: op_load(8'($urandom), 1'($urandom), 1'($urandom), nw, "rnd_ld");
        1: op_read(nw, -1, "rnd_rd");
        default: op_write($urandom, nw, "rnd_wr");
      endcase
    end

    j = rnd38(); j[34:3] = 32'hCAFE0001;
    pulse(1'b0, 1'b0, 1'b1, j);
    avm_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw.pre", 32'(avm_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw.drop", 32'(avm_write), 32'd0);
    @(negedge clk);
    chk("rstw.mond", MonDReg, 32'd0);
    chk("rstw.mona", 32'({avm_address, MonAReg}), 32'd0);
    chk("rstw.wdata", avm_writedata, 32'd0);
    chk("rstw.flags", 32'({avm_read, avm_write, ocimem_busy, ocimem_err}), 32'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    m_a = '0; m_d = '0; m_err = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (avm_write || avm_read || ocimem_busy) seen = 1'b1;
    end
    chk("rstw.quiet", 32'(seen), 32'd0);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("memimage", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
